// File: rtl/diffusion_err_store.sv
// diffusion_err_store: splits per-macroblock chroma dither errors into left carry and a top row buffer,
// clears the row buffer at frame start and serves top/left errors to the quantiser.
module diffusion_err_store #(
  parameter int CH = 2,
  parameter int EW = 8,
  parameter int AW = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic [AW-1:0]        mb_w,
  input  logic                 store_valid,
  output logic                 store_ready,
  input  logic [AW-1:0]        store_x,
  input  logic [CH*3*EW-1:0]   store_derr,
  input  logic                 load_req,
  input  logic [AW-1:0]        load_x,
  output logic                 load_vld,
  output logic [CH*2*EW-1:0]   load_top,
  output logic [CH*2*EW-1:0]   load_left,
  output logic                 busy,
  output logic                 err_oob
);
  localparam int LW = CH*2*EW;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;
  state_t state, state_nx;
  logic [AW-1:0] mbw, cnt, waddr;
  logic [LW-1:0] left_q, top_nw, left_nw, wdata;
  logic [LW-1:0] mem [2**AW];
  logic we, st_acc, st_oob, ld_ok, ld_oob;
  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [EW-1:0] d0, d1, d2, l1;
    logic signed [EW+1:0] d2x, p, q;
    logic [EW-1:0] t1;
    assign d0 = store_derr[c*3*EW +: EW];
    assign d1 = store_derr[c*3*EW+EW +: EW];
    assign d2 = store_derr[c*3*EW+2*EW +: EW];
    assign d2x = {{2{d2[EW-1]}}, d2};
    assign p = d2x + (d2x <<< 1);
    assign q = p >>> 2;
    assign l1 = q[EW-1:0];
    assign t1 = d2 - l1;
    assign top_nw[c*2*EW +: 2*EW] = {t1, d1};
    assign left_nw[c*2*EW +: 2*EW] = {l1, d0};
  end
  assign store_ready = state == RUN;
  assign busy = state == CLEAR;
  assign st_acc = store_ready && store_valid && !frame_start;
  assign st_oob = st_acc && store_x >= mbw;
  assign ld_ok = store_ready && load_req && !frame_start;
  assign ld_oob = ld_ok && load_x >= mbw;
  assign we = (busy && !frame_start) || (st_acc && !st_oob);
  assign waddr = busy ? cnt : store_x;
  assign wdata = busy ? '0 : top_nw;
  always_comb begin
    state_nx = state;
    if (frame_start) state_nx = CLEAR;
    else if (busy && cnt == mbw - 1'b1) state_nx = RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mbw <= '0;
      cnt <= '0;
      left_q <= '0;
      err_oob <= 1'b0;
      load_vld <= 1'b0;
      load_top <= '0;
      load_left <= '0;
    end else begin
      state <= state_nx;
      load_vld <= ld_ok;
      if (frame_start) begin
        mbw <= mb_w == '0 ? AW'(1) : mb_w;
        cnt <= '0;
        left_q <= '0;
        err_oob <= 1'b0;
      end else begin
        if (busy) cnt <= cnt + 1'b1;
        if (we && !busy) left_q <= left_nw;
        if (st_oob || ld_oob) err_oob <= 1'b1;
      end
      // write-first: a same-cycle store is forwarded to the load result
      if (ld_ok) begin
        load_top <= ld_oob ? '0 : (we && waddr == load_x) ? wdata : mem[load_x];
        load_left <= (ld_oob || load_x == '0) ? '0 : (we && !busy) ? left_nw : left_q;
      end
    end
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
endmodule

// File: tb/tb_diffusion_err_store.sv
// tb_diffusion_err_store: directed-vector bench for diffusion_err_store (CH=2, EW=8, AW=10).
module tb_diffusion_err_store;
  logic clk = 0, rst_n = 0, frame_start = 0, store_valid = 0, load_req = 0;
  logic [9:0] mb_w = '0, store_x = '0, load_x = '0;
  logic [47:0] store_derr = '0;
  logic store_ready, load_vld, busy, err_oob;
  logic [31:0] load_top, load_left;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  diffusion_err_store dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .mb_w(mb_w),
    .store_valid(store_valid), .store_ready(store_ready), .store_x(store_x),
    .store_derr(store_derr), .load_req(load_req), .load_x(load_x),
    .load_vld(load_vld), .load_top(load_top), .load_left(load_left),
    .busy(busy), .err_oob(err_oob)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    #3;
    chk("rst_ready", 64'(store_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_vld", 64'(load_vld), 64'd0);
    chk("rst_top", 64'(load_top), 64'd0);
    chk("rst_left", 64'(load_left), 64'd0);
    chk("rst_oob", 64'(err_oob), 64'd0);
    rst_n = 1;
    tick();
    chk("idle_ready", 64'(store_ready), 64'd0);
    frame_start = 1; mb_w = 10'd4;
    tick();
    frame_start = 0; load_req = 1; load_x = 10'd0;
    for (int i = 0; i < 4; i++) begin
      chk("clr_busy", 64'(busy), 64'd1);
      chk("clr_ready", 64'(store_ready), 64'd0);
      tick();
      chk("clr_novld", 64'(load_vld), 64'd0);
    end
    chk("run_busy", 64'(busy), 64'd0);
    chk("run_ready", 64'(store_ready), 64'd1);
    load_x = 10'd2;
    tick();
    load_req = 0;
    chk("ld2_vld", 64'(load_vld), 64'd1);
    chk("ld2_top", 64'(load_top), 64'd0);
    chk("ld2_left", 64'(load_left), 64'd0);
    tick();
    chk("ld_pulse", 64'(load_vld), 64'd0);
    store_valid = 1; store_x = 10'd1;
    store_derr = {8'hF9, 8'h20, 8'h10, 8'h07, 8'hFD, 8'h05};
    tick();
    store_valid = 0; load_req = 1; load_x = 10'd2;
    tick();
    chk("l2_left", 64'(load_left), 64'hFA10_0505);
    chk("l2_top", 64'(load_top), 64'd0);
    load_x = 10'd1;
    tick();
    chk("l1_top", 64'(load_top), 64'hFF20_02FD);
    chk("l1_left", 64'(load_left), 64'hFA10_0505);
    load_x = 10'd0;
    tick();
    chk("l0_left", 64'(load_left), 64'd0);
    chk("l0_top", 64'(load_top), 64'd0);
    store_valid = 1; store_x = 10'd3; load_x = 10'd3;
    store_derr = {8'h80, 8'h7F, 8'h80, 8'h04, 8'h02, 8'h01};
    tick();
    store_valid = 0; load_req = 0;
    chk("rdw_vld", 64'(load_vld), 64'd1);
    chk("rdw_top", 64'(load_top), 64'hE07F_0102);
    chk("rdw_left", 64'(load_left), 64'hA080_0301);
    chk("rdw_oob", 64'(err_oob), 64'd0);
    tick();
    chk("hold_vld", 64'(load_vld), 64'd0);
    chk("hold_top", 64'(load_top), 64'hE07F_0102);
    store_valid = 1; store_x = 10'd5; store_derr = 48'h1111_2222_3333;
    tick();
    store_valid = 0;
    chk("st_oob", 64'(err_oob), 64'd1);
    load_req = 1; load_x = 10'd5;
    tick();
    chk("lo_vld", 64'(load_vld), 64'd1);
    chk("lo_top", 64'(load_top), 64'd0);
    chk("lo_left", 64'(load_left), 64'd0);
    load_x = 10'd3;
    tick();
    load_req = 0;
    chk("keep_top", 64'(load_top), 64'hE07F_0102);
    chk("keep_left", 64'(load_left), 64'hA080_0301);
    frame_start = 1; mb_w = 10'd4;
    tick();
    frame_start = 0;
    chk("fs_oob", 64'(err_oob), 64'd0);
    chk("fs_busy", 64'(busy), 64'd1);
    tick();
    frame_start = 1; mb_w = 10'd2;
    tick();
    frame_start = 0; load_req = 1; load_x = 10'd0;
    chk("rc_busy0", 64'(busy), 64'd1);
    tick();
    chk("rc_busy1", 64'(busy), 64'd1);
    chk("rc_novld", 64'(load_vld), 64'd0);
    load_req = 0;
    tick();
    chk("rc_ready", 64'(store_ready), 64'd1);
    chk("rc_nobusy", 64'(busy), 64'd0);
    load_req = 1; load_x = 10'd1;
    tick();
    chk("rc_top", 64'(load_top), 64'd0);
    chk("rc_left", 64'(load_left), 64'd0);
    chk("rc_oob0", 64'(err_oob), 64'd0);
    load_x = 10'd3;
    tick();
    load_req = 0;
    chk("rc_lvld", 64'(load_vld), 64'd1);
    chk("rc_ltop", 64'(load_top), 64'd0);
    chk("rc_oob1", 64'(err_oob), 64'd1);
    frame_start = 1; store_valid = 1; store_x = 10'd1; store_derr = 48'h0102_0304_0506;
    tick();
    frame_start = 0; store_valid = 0;
    chk("mr_busy", 64'(busy), 64'd1);
    chk("mr_oob", 64'(err_oob), 64'd0);
    tick();
    tick();
    chk("mr_ready", 64'(store_ready), 64'd1);
    load_req = 1; load_x = 10'd1;
    tick();
    load_req = 0;
    chk("mr_top", 64'(load_top), 64'd0);
    chk("mr_left", 64'(load_left), 64'd0);
    store_valid = 1; store_x = 10'd1;
    store_derr = {8'hF9, 8'h20, 8'h10, 8'h07, 8'hFD, 8'h05};
    tick();
    store_valid = 0; load_req = 1;
    tick();
    load_req = 0;
    chk("pre_top", 64'(load_top), 64'hFF20_02FD);
    #2 rst_n = 0;
    #1;
    chk("ar_ready", 64'(store_ready), 64'd0);
    chk("ar_vld", 64'(load_vld), 64'd0);
    chk("ar_top", 64'(load_top), 64'd0);
    chk("ar_left", 64'(load_left), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    rst_n = 1;
    tick();
    tick();
    chk("ar_idle", 64'(store_ready), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/diffusion_err_store.md
Name: diffusion_err_store

Overview:
- Per-macroblock dithering diffusion-error store for the chroma path, parametrised in channel count and error width.
- Accepts each macroblock's signed error triplets and splits them into "left" errors (held for the next macroblock in the row) and "top" errors (kept in an internal row buffer for the next macroblock row).
- Owns its own top-error RAM and zero-initialises it at frame start via a clear FSM.
- Serves a load port so the quantiser can fetch top/left errors before processing macroblock x.

Parameters:
- CH, 2, number of chroma channels (error triplets per macroblock).
- EW, 8, width of one signed error value.
- AW, 10, row-buffer address width; buffer depth is 2**AW macroblocks.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  single-cycle pulse: restart frame, sample mb_w, clear buffers
- mb_w  in  AW  macroblocks per row, sampled on frame_start
- store_valid  in  1  store request
- store_ready  out  1  store accepted when valid&ready
- store_x  in  AW  macroblock column of stored errors
- store_derr  in  CH*3*EW  channel c triplet {d2,d1,d0} at bits [c*3*EW +: 3*EW], d0 is LSB
- load_req  in  1  load request
- load_x  in  AW  column to load
- load_vld  out  1  load data valid, one-cycle pulse
- load_top  out  CH*2*EW  channel c {t1,t0} at [c*2*EW +: 2*EW]
- load_left  out  CH*2*EW  channel c {l1,l0}, same packing
- busy  out  1  high while clearing
- err_oob  out  1  sticky: store or load with x >= mb_w since the last frame_start

Behaviour:
- Reset: FSM=IDLE; all outputs 0, including store_ready, load_vld, load_top, load_left, busy and err_oob. Left registers are 0. RAM contents are undefined.
- FSM states: IDLE, CLEAR, RUN.
- frame_start in any state:
  - Goes to CLEAR, latches mb_w (0 is treated as 1) and sets the clear counter to 0.
  - Zeroes the left registers and clears err_oob.
  - Aborts any in-flight store. frame_start has priority over everything else that cycle.
- CLEAR:
  - busy=1 and store_ready=0.
  - Each cycle writes 0 to RAM[cnt] and increments cnt.
  - After writing cnt == mb_w-1, moves to RUN. CLEAR lasts exactly mb_w cycles.
  - load_req is ignored (no load_vld).
- IDLE: store_ready=0; load_req is ignored.
- RUN: store_ready=1.
- Store arithmetic, per channel, signed EW:
  - l0 = d0
  - l1 = (3*d2) >>> 2, computed at EW+2 bits, arithmetic shift, truncated to EW
  - t0 = d1
  - t1 = d2 - l1, truncated to EW
- Store accept (RUN, valid&ready, store_x < mb_w):
  - On the accepting edge, RAM[store_x] <= {t1,t0} for all channels.
  - On the same edge, the left registers <= {l1,l0}.
  - store_x >= mb_w: no RAM or left update, and err_oob sets.
- Load (RUN, load_req):
  - Exactly 1-cycle latency: load_vld=1 on the next cycle with load_top=RAM[load_x].
  - load_left = left registers if load_x != 0, else 0, so the row start sees zero left error.
  - load_x >= mb_w returns all-zero data with load_vld=1, and err_oob sets.
- Read-during-write on the same address in the same cycle: write-first, so load_top returns the newly stored value. load_left likewise returns the left values from that store.
- load_top and load_left hold their last value when load_vld=0.
- RAM: single write port, single read port, registered read, depth 2**AW.

Test Plan:
- Reset then frame_start with mb_w=4 -> busy high for 4 cycles, RAM[0..3]=0, store_ready rises on cycle 5; load_x=2 returns load_top=0, load_left=0.
- RUN, CH=2, EW=8, store x=1 with ch0 d0=5, d1=-3, d2=7 -> ch0 l0=5, l1=5, t0=-3 (0xFD), t1=2. Store ch1 d2=-7 -> l1=-6 (0xFA), t1=-1. Then load x=2 returns these left values and load x=1 returns these top values.
- Same-cycle store and load at x=3 -> load_vld next cycle, load_top equals the new t values (write-first).
- store_x=5 with mb_w=4 -> RAM unchanged, err_oob=1. Then frame_start -> err_oob=0 and RAM is re-cleared.
- frame_start asserted in mid-CLEAR and mid-RUN with mb_w changed to 2 -> CLEAR restarts from 0 and lasts 2 cycles; loads during CLEAR give no load_vld.
- Async rst_n pulse during RUN -> all outputs 0 immediately, FSM=IDLE, store_ready stays 0 until the next frame_start.
